// File: rtl/led_share_arbiter.sv
// rtl/led_share_arbiter.sv - round-robin LED bank arbiter with minimum dwell and blank switch cycle
// Optional macro LED_ARB_PRIORITY_EN: requester 0 is high priority and preempts without dwell.
module led_share_arbiter #(
  parameter int                  CLK_FREQ     = 300_000_000,
  parameter int                  LED_NUM      = 8,
  parameter int                  REQ_NUM      = 4,
  parameter int                  DWELL_MS     = 500,
  parameter logic [LED_NUM-1:0]  IDLE_PATTERN = '0
) (
  input  logic                       CLK_i,
  input  logic                       RSTn_i,
  input  logic [REQ_NUM-1:0]         REQ_i,
  input  logic [REQ_NUM*LED_NUM-1:0] PAT_i,
  output logic [REQ_NUM-1:0]         GNT_o,
  output logic [LED_NUM-1:0]         LED_o,
  output logic                       BUSY_o
);

  localparam int TICK_DIV = CLK_FREQ / 1000;
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW_W     = (DWELL_MS > 0) ? $clog2(DWELL_MS + 1) : 1;
  localparam int PTR_W    = $clog2(REQ_NUM);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SWITCH} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PS_W-1:0]    prescaler_q;
  logic [PS_W-1:0]    prescaler_d;
  logic [DW_W-1:0]    dwell_q;
  logic [DW_W-1:0]    dwell_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic               tick;
  logic               dwell_done;
  logic               owner_req;
  logic               other_req;
  logic               preempt;
  logic [PTR_W-1:0]   next_ptr;
  logic [LED_NUM-1:0] owner_pat;

  // Rotating search starting at rr_ptr_q; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(REQ_NUM))
        cand = cand - (PTR_W+1)'(REQ_NUM);
      if (REQ_i[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
`ifdef LED_ARB_PRIORITY_EN
    if (REQ_i[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    tick        = (prescaler_q == PS_W'(TICK_DIV - 1));
    prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);
    dwell_done  = (dwell_q == DW_W'(DWELL_MS));
    dwell_d     = (tick && !dwell_done) ? dwell_q + DW_W'(1) : dwell_q;
    owner_req   = REQ_i[owner_q];
    other_req   = |(REQ_i & ~(REQ_NUM'(1) << owner_q));
    preempt     = dwell_done && other_req;
`ifdef LED_ARB_PRIORITY_EN
    if (owner_q != '0 && REQ_i[0])
      preempt = 1'b1;
`endif
    next_ptr    = (owner_q == PTR_W'(REQ_NUM - 1)) ? '0 : owner_q + PTR_W'(1);
    owner_pat   = PAT_i[int'(owner_q)*LED_NUM +: LED_NUM];
  end

  always_ff @(posedge CLK_i) begin
    if (!RSTn_i) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      prescaler_q <= '0;
      dwell_q     <= '0;
      GNT_o       <= '0;
      LED_o       <= IDLE_PATTERN;
      BUSY_o      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_SWITCH: begin
          LED_o <= IDLE_PATTERN;
          if (win_found) begin
            state_q     <= S_GRANT;
            owner_q     <= win_idx;
            GNT_o       <= REQ_NUM'(1) << win_idx;
            BUSY_o      <= 1'b1;
            prescaler_q <= '0;
            dwell_q     <= '0;
          end else begin
            state_q <= S_IDLE;
            GNT_o   <= '0;
            BUSY_o  <= 1'b0;
          end
        end
        S_GRANT: begin
          // Release wins over preempt; both take the same blank-cycle path.
          if (!owner_req || preempt) begin
            state_q <= S_SWITCH;
            GNT_o   <= '0;
            BUSY_o  <= 1'b0;
            LED_o   <= IDLE_PATTERN;
`ifdef LED_ARB_PRIORITY_EN
            if (owner_q != '0)
              rr_ptr_q <= next_ptr;
`else
            rr_ptr_q <= next_ptr;
`endif
          end else begin
            LED_o       <= owner_pat;
            prescaler_q <= prescaler_d;
            dwell_q     <= dwell_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          GNT_o   <= '0;
          BUSY_o  <= 1'b0;
          LED_o   <= IDLE_PATTERN;
        end
      endcase
    end
  end

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Shares the on-board LED bank between several pattern sources, e.g. the water-light generator, a status blinker and a debug display.
- Round-robin arbiter with a minimum dwell time per owner.
- Muxes the granted source's pattern onto the LED pins and inserts a one-cycle blank between owners.
- Sits between the pattern generators and the top-level LED output, in the board's system clock domain.

Parameters:
- CLK_FREQ, 300_000_000, system clock frequency in Hz; the 1 ms tick is derived from it.
- LED_NUM, 8, number of LEDs driven.
- REQ_NUM, 4, number of requesters (>=2).
- DWELL_MS, 500, minimum ms an owner keeps the bank before a waiting requester may preempt it.
- IDLE_PATTERN, 0, LED_NUM-bit value driven when no owner / during the switch cycle.

Ports:
- CLK_i  input  1  system clock (BUFG output).
- RSTn_i  input  1  synchronous reset, active low.
- REQ_i  input  REQ_NUM  level request per requester; held high while it wants the LEDs.
- PAT_i  input  REQ_NUM*LED_NUM  packed patterns; requester k occupies bits [k*LED_NUM +: LED_NUM].
- GNT_o  output  REQ_NUM  one-hot grant, registered.
- LED_o  output  LED_NUM  registered LED drive.
- BUSY_o  output  1  high while any grant is active.

Behaviour:
- All state updates on the rising edge of CLK_i. RSTn_i is sampled only at the clock edge; it is synchronous, active low.
- Reset values: GNT_o=0, LED_o=IDLE_PATTERN, BUSY_o=0, state=IDLE, rr_ptr=0, prescaler=0, dwell=0.
- Reset asserted mid-grant aborts the grant; all outputs take reset values on that edge.
- ms tick: prescaler counts 0..CLK_FREQ/1000-1 and pulses tick at the terminal count.
  - Width is $clog2(CLK_FREQ/1000).
  - Cleared on every new grant, so dwell is measured from the grant.
- dwell counter:
  - Width $clog2(DWELL_MS+1).
  - Increments on tick while in GRANT and saturates at DWELL_MS; cleared on new grant.
  - dwell_done = (dwell==DWELL_MS). DWELL_MS=0 means dwell_done is true immediately.
- Arbitration (in IDLE and SWITCH): winner is the first k with REQ_i[k]=1, searching rr_ptr, rr_ptr+1, ... modulo REQ_NUM. The search wraps REQ_NUM-1 -> 0.
- FSM:
  - IDLE: no REQ -> stay, LED_o=IDLE_PATTERN. Any REQ -> GRANT; GNT_o/BUSY_o assert on the next edge (1-cycle latency from REQ to GNT).
  - GRANT:
    - LED_o <= owner's PAT_i every cycle (1-cycle register latency; pattern changes track live).
    - Owner's REQ low -> SWITCH.
    - dwell_done and any other REQ high -> SWITCH (preempt).
    - Otherwise stay. A sole requester holds indefinitely regardless of dwell.
  - SWITCH: exactly one cycle.
    - GNT_o=0, BUSY_o=0, LED_o=IDLE_PATTERN; rr_ptr <= (owner+1) mod REQ_NUM.
    - Next edge arbitrates with the updated pointer: any REQ -> GRANT, else IDLE.
    - The previous owner may win again only if no other requester is high.
- Timing guarantees:
  - Release or preempt condition sampled at edge t -> GNT_o=0 after edge t -> new GNT_o after edge t+1.
  - GNT_o is never multi-hot.
  - LED_o never shows a non-owner pattern.
- Simultaneous owner release and preempt condition: treated as release, same path.
- REQ pulses shorter than one cycle or dropped before grant are simply lost; there is no queuing.

Optional Feature:
- Macro LED_ARB_PRIORITY_EN.
- Defined:
  - Requester 0 is high priority and always wins arbitration when REQ_i[0]=1, ignoring rr_ptr.
  - In GRANT with owner!=0, REQ_i[0]=1 preempts immediately (goes to SWITCH) without waiting for dwell_done.
  - After requester 0 releases, rr_ptr is left unchanged rather than advanced.
- Undefined: pure round-robin as above; requester 0 has no special treatment.

Test Plan:
Bench parameters unless stated: CLK_FREQ=10_000 (tick every 10 cycles), DWELL_MS=3 (30 cycles), LED_NUM=8, REQ_NUM=4.
1. Reset: hold RSTn_i=0 for 5 cycles with REQ_i=4'b1111 -> GNT_o=0, LED_o=8'h00, BUSY_o=0 throughout. Release -> GNT_o=4'b0001 one edge later.
2. Single requester: REQ_i=4'b0100, PAT slot2=8'hA5 -> GNT_o=4'b0100 after 1 cycle, LED_o=8'hA5 after 2 cycles. Held 200 cycles with no change. Drop REQ -> GNT_o=0 next edge, LED_o=8'h00.
3. Preempt after dwell: owner 0 granted, REQ_i[3] raised at cycle 5 of the grant -> grant persists until dwell=3 (30 cycles), then one SWITCH cycle, then GNT_o=4'b1000.
4. Round-robin wrap: all four requesting continuously -> grant order 0,1,2,3,0. Each grant lasts 30 cycles plus a 1 blank cycle, with LED_o=8'h00 in each gap.
5. DWELL_MS=0: requesters 1 and 2 both high -> grants alternate 1,2,1,2. Each lasts 1 cycle with a 1-cycle gap between.
6. With LED_ARB_PRIORITY_EN: owner 2 at dwell=1, raise REQ_i[0] -> SWITCH next edge, then GNT_o=4'b0001. After it releases, the next grant follows from the unchanged rr_ptr.
